// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_FIFO_DEPTH   = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_e;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO; DEPTH must be a power of two (>= 2).
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = DATA_W
) (
    input  logic                       Clk_CPU,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Head reads as zero while empty so rx_data is clean after reset.
    assign head_o  = empty_o ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
        else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge Clk_CPU or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clk_CPU) begin
        if (push_ok) mem[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a FWFT FIFO
// with sticky overrun / framing / parity error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                          Clk_CPU,
    input  logic                          rst,
    input  logic                          rx_i,
    input  logic                          rd_en,
    input  logic                          err_clear,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    output logic                          frame_err,
    output logic                          parity_err
);

    localparam int             CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  HALF_BIT = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]  FULL_BIT = CW'(CLKS_PER_BIT);

    logic              sync1_q, sync2_q, rx_prev_q;
    logic              rx_s;
    rx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              sample;
    logic              push;
    logic              frame_set;
    logic              drop;
    logic              fifo_full, fifo_empty;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;

    assign rx_s   = sync2_q;
    // Sample when the countdown reaches 1 so bit samples are exactly CLKS_PER_BIT apart.
    assign sample = (cnt_q == CW'(1));

`ifdef UART_RX_PARITY_EN
    logic parity_bad_q, parity_bad_d;
    logic par_set;
    logic parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
        par_set      = 1'b0;
`endif
        if (state_q != IDLE && !sample) cnt_d = cnt_q - CW'(1);

        case (state_q)
            IDLE: begin
                // Edge-triggered so a held-low break after a bad stop bit cannot retrigger.
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                    cnt_d   = HALF_BIT;
                end
            end
            START: begin
                if (sample) begin
                    cnt_d     = FULL_BIT;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    cnt_d     = FULL_BIT;
                    shift_d   = {rx_s, shift_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample) begin
                    cnt_d        = FULL_BIT;
                    parity_bad_d = (rx_s != even_parity(shift_q));
                    state_d      = STOP;
                end
            end
`endif
            STOP: begin
                if (sample) begin
                    state_d = IDLE;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        if (parity_bad_q) par_set = 1'b1;
                        else              push    = 1'b1;
`else
                        push = 1'b1;
`endif
                    end else begin
                        frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_set = parity_bad_q;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO only loses the byte when nothing is popped in the same cycle.
    assign drop        = push && fifo_full && !rd_en;
    assign overrun_d   = drop      | (overrun_q   & ~err_clear);
    assign frame_err_d = frame_set | (frame_err_q & ~err_clear);

    always_ff @(posedge Clk_CPU or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= rx_i;
            sync2_q     <= sync1_q;
            rx_prev_q   <= rx_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err_d = par_set | (parity_err_q & ~err_clear);

    always_ff @(posedge Clk_CPU or posedge rst) begin
        if (rst) begin
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign rx_valid  = !fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .Clk_CPU (Clk_CPU),
        .rst     (rst),
        .push_i  (push),
        .data_i  (shift_q),
        .pop_i   (rd_en),
        .head_o  (rx_data),
        .count_o (rx_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=16, FIFO_DEPTH=8.
// Parity cases are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Start bit driven just after edge 0: 2 sync flops + edge detect put START at edge 3,
    // mid-start sample at edge 11, stop sample 16*(NBITS-1) later; byte visible right after it.
    localparam int LAT = 11 + CPB * (NBITS - 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clear = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] rx_count;
    logic       overrun, frame_err, parity_err;

    int tests_run = 0;
    int tests_failed = 0;
    int valid_at;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .Clk_CPU    (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .rd_en      (rd_en),
        .err_clear  (err_clear),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_count   (rx_count),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 err_clear = 1'b1;
        @(posedge clk); #1 err_clear = 1'b0;
    endtask

    // Drives one frame cycle by cycle; optionally raises rd_en for the cycle index pop_at
    // and reports the cycle index at which rx_valid first rose (-1 if never).
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit,
                              input int pop_at, output int v_at);
        logic [10:0] fb;
        logic        seen;
        fb      = '1;
        fb[0]   = 1'b0;
        fb[8:1] = data;
`ifdef UART_RX_PARITY_EN
        fb[9]   = par_bit;
        fb[10]  = stop_bit;
`else
        fb[9]   = stop_bit;
        fb[10]  = par_bit;
`endif
        v_at = -1;
        seen = rx_valid;
        for (int k = 0; k < NBITS * CPB; k++) begin
            @(posedge clk); #1;
            if (rx_valid && !seen && v_at < 0) v_at = k;
            seen  = rx_valid;
            rx_i  = fb[k / CPB];
            rd_en = (k == pop_at);
        end
        rd_en = 1'b0;
    endtask

    task automatic send_ok(input logic [7:0] data);
        int dummy;
        send_frame(data, 1'b1, ^data, -1, dummy);
        idle(4);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", rx_valid, 0);
        check("reset_count", rx_count, 0);
        check("reset_data", rx_data, 0);
        check("reset_flags", {overrun, frame_err, parity_err}, 0);
        rst = 1'b0;
        idle(10);

        // Single byte, latency, pop
        send_frame(8'hA5, 1'b1, ^8'hA5, -1, valid_at);
        check("a5_latency", valid_at, LAT);
        idle(4);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_count", rx_count, 1);
        pop();
        check("a5_popped_valid", rx_valid, 0);
        pop();
        check("empty_pop_count", rx_count, 0);

        // Overrun on 9th byte
        for (int i = 1; i <= 9; i++) send_ok(8'(i));
        check("ovr_count", rx_count, 8);
        check("ovr_head", rx_data, 8'h01);
        check("ovr_flag", overrun, 1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovr_pop%0d", i), rx_data, 32'(i));
            pop();
        end
        check("ovr_drained", rx_valid, 0);
        check("ovr_sticky", overrun, 1);
        pulse_clear();
        check("ovr_cleared", overrun, 0);

        // Full FIFO, push and pop in the same cycle
        for (int i = 0; i < 8; i++) send_ok(8'h10 + 8'(i));
        check("full_count", rx_count, 8);
        send_frame(8'h55, 1'b1, ^8'h55, LAT - 1, valid_at);
        idle(4);
        check("pp_count", rx_count, 8);
        check("pp_overrun", overrun, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp_pop%0d", i), rx_data, (i < 7) ? 32'(8'h11 + i) : 32'h55);
            pop();
        end
        check("pp_drained", rx_count, 0);

        // Start-bit glitch
        rx_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(30);
        check("glitch_count", rx_count, 0);
        check("glitch_flags", {overrun, frame_err, parity_err}, 0);
        check("glitch_idle", 32'(dut.state_q), 32'(IDLE));
        send_ok(8'h5A);
        check("post_glitch_data", rx_data, 8'h5A);
        pop();

        // Framing error followed by a held-low break
        send_frame(8'h3C, 1'b0, ^8'h3C, -1, valid_at);
        repeat (40) @(posedge clk);
        #1;
        check("fe_flag", frame_err, 1);
        check("fe_count", rx_count, 0);
        check("fe_break_idle", 32'(dut.state_q), 32'(IDLE));
        idle(40);
        check("fe_no_retrigger", rx_count, 0);
        pulse_clear();
        check("fe_cleared", frame_err, 0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, -1, valid_at);
        idle(4);
        check("par_flag", parity_err, 1);
        check("par_discard", rx_count, 0);
        send_ok(8'h07);
        check("par_good_data", rx_data, 8'h07);
        check("par_sticky", parity_err, 1);
        pop();
        pulse_clear();
        check("par_cleared", parity_err, 0);
`else
        check("par_tied_low", parity_err, 0);
`endif

        // Reset mid-DATA with a byte queued and a flag set
        send_ok(8'h99);
        send_frame(8'h3C, 1'b0, ^8'h3C, -1, valid_at);
        idle(4);
        @(posedge clk); #1 rx_i = 1'b0;
        repeat (CPB) @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (CPB * 2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", rx_valid, 0);
        check("rst_async_outs", {rx_data, rx_count, overrun, frame_err, parity_err}, 0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(CPB * 10);
        check("rst_no_push", rx_count, 0);
        send_ok(8'hC3);
        check("rst_resume_data", rx_data, 8'hC3);
        check("rst_resume_count", rx_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
